// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO sizing defaults and status FSM state encodings
package fifo_pkg;
    localparam int DEF_MEM_SIZE = 8;
    localparam int DEF_PTR      = 3;
    localparam int CNT_W        = DEF_PTR + 1;
    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_ACTIVE = 3'd2;
    localparam logic [2:0] S_FULL   = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;
endpackage

// File: rtl/fifo_status_ctrl.sv
// fifo_status_ctrl: FIFO occupancy counter, status flags, sticky errors and coarse FSM
//   clk, reset (sync, active-high)
//   push, pop                  qualified write/read strobes
//   umbral_bajo, umbral_alto   almost-empty/full thresholds, latched in INIT only
//   fifo_count                 occupancy 0..MEM_SIZE
//   fifo_empty, fifo_full, almost_empty, almost_full  registered-state decodes
//   error_overflow, error_underflow                   sticky until reset
//   state                      FSM state (encodings in fifo_pkg)
module fifo_status_ctrl
    import fifo_pkg::*;
#(
    parameter int MEM_SIZE = DEF_MEM_SIZE,
    parameter int PTR      = DEF_PTR
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [PTR:0] umbral_bajo,
    input  logic [PTR:0] umbral_alto,
    output logic [PTR:0] fifo_count,
    output logic         fifo_empty,
    output logic         fifo_full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic         error_overflow,
    output logic         error_underflow,
    output logic [2:0]   state
);
    localparam logic [PTR:0] FULL_CNT = (PTR+1)'(MEM_SIZE);
    logic [PTR:0] th_lo, th_hi, nxt_cnt;
    logic         inc, dec, ovf_ev, unf_ev;
    assign inc    = push & ~pop;
    assign dec    = pop & ~push;
    assign ovf_ev = inc & fifo_full;
    assign unf_ev = dec & fifo_empty;
    // Illegal strobes leave the count untouched so it never wraps.
    assign nxt_cnt = (ovf_ev | unf_ev) ? fifo_count :
                     inc ? fifo_count + 1'b1 :
                     dec ? fifo_count - 1'b1 : fifo_count;
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_count      <= '0;
            state           <= S_INIT;
            error_overflow  <= 1'b0;
            error_underflow <= 1'b0;
            th_lo           <= '0;
            th_hi           <= '0;
        end else if (state == S_ERROR) begin
            state <= S_ERROR;
        end else if (state > S_ERROR) begin
            state <= S_INIT;
        end else begin
            if (state == S_INIT) begin
                th_lo <= umbral_bajo;
                th_hi <= umbral_alto;
            end
            fifo_count      <= nxt_cnt;
            error_overflow  <= error_overflow | ovf_ev;
            error_underflow <= error_underflow | unf_ev;
            // Legal states follow the updated count, so INIT/IDLE/ACTIVE/FULL share one rule.
            state <= (ovf_ev | unf_ev) ? S_ERROR :
                     (nxt_cnt == '0) ? S_IDLE :
                     (nxt_cnt == FULL_CNT) ? S_FULL : S_ACTIVE;
        end
    end
    assign fifo_empty   = fifo_count == '0;
    assign fifo_full    = fifo_count == FULL_CNT;
    assign almost_empty = fifo_count <= th_lo;
    assign almost_full  = fifo_count >= th_hi;
endmodule

// File: tb/tb_fifo_status_ctrl.sv
// tb_fifo_status_ctrl: scoreboard bench with a behavioural occupancy model
module tb_fifo_status_ctrl;
    typedef struct packed {
        logic [3:0] cnt;
        logic       em, fu, ae, af, ov, un;
        logic [2:0] st;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push = 1'b0, pop = 1'b0;
    logic [3:0] umbral_bajo = 4'd0, umbral_alto = 4'd0;
    logic [3:0] fifo_count;
    logic       fifo_empty, fifo_full, almost_empty, almost_full;
    logic       error_overflow, error_underflow;
    logic [2:0] state;

    fifo_status_ctrl #(.MEM_SIZE(8), .PTR(3)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .umbral_bajo(umbral_bajo), .umbral_alto(umbral_alto),
        .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .almost_empty(almost_empty), .almost_full(almost_full),
        .error_overflow(error_overflow), .error_underflow(error_underflow),
        .state(state)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int total = 0, bad = 0, step = 0;

    int m_cnt = 0, m_lo = 0, m_hi = 0;
    bit m_ov = 0, m_un = 0, m_init = 1, m_dead = 0;

    task automatic cyc(input bit r, input bit p, input bit o, input int lo, input int hi);
        exp_t e;
        @(negedge clk);
        reset = r; push = p; pop = o;
        umbral_bajo = 4'(lo); umbral_alto = 4'(hi);
        if (r) begin
            m_cnt = 0; m_lo = 0; m_hi = 0;
            m_ov = 0; m_un = 0; m_init = 1; m_dead = 0;
        end else if (!m_dead) begin
            if (m_init) begin
                m_lo = lo; m_hi = hi; m_init = 0;
            end
            if (p && !o) begin
                if (m_cnt == 8) begin m_ov = 1; m_dead = 1; end
                else m_cnt++;
            end else if (o && !p) begin
                if (m_cnt == 0) begin m_un = 1; m_dead = 1; end
                else m_cnt--;
            end
        end
        e.cnt = 4'(m_cnt);
        e.em  = m_cnt == 0;
        e.fu  = m_cnt == 8;
        e.ae  = m_cnt <= m_lo;
        e.af  = m_cnt >= m_hi;
        e.ov  = m_ov;
        e.un  = m_un;
        e.st  = m_init ? 3'd0 : m_dead ? 3'd4 : m_cnt == 0 ? 3'd1 : m_cnt == 8 ? 3'd3 : 3'd2;
        q.push_back(e);
    endtask

    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {fifo_count, fifo_empty, fifo_full, almost_empty, almost_full,
                     error_overflow, error_underflow, state};
                step++;
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL step%0d: got cnt=%0d em=%b fu=%b ae=%b af=%b ov=%b un=%b st=%0d want cnt=%0d em=%b fu=%b ae=%b af=%b ov=%b un=%b st=%0d",
                             step, a.cnt, a.em, a.fu, a.ae, a.af, a.ov, a.un, a.st,
                             e.cnt, e.em, e.fu, e.ae, e.af, e.ov, e.un, e.st);
                end
            end
        end
    end

    initial begin
        int lo, hi;
        cyc(1, 0, 0, 2, 6);
        cyc(0, 0, 0, 2, 6);
        cyc(0, 0, 0, 2, 6);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 2, 6);
        cyc(0, 1, 1, 2, 6);
        cyc(0, 1, 0, 2, 6);
        cyc(0, 0, 1, 2, 6);
        cyc(0, 0, 1, 2, 6);
        cyc(1, 0, 0, 2, 6);
        cyc(0, 0, 0, 2, 6);
        cyc(0, 1, 1, 2, 6);
        cyc(0, 0, 1, 2, 6);
        cyc(0, 1, 0, 2, 6);
        cyc(1, 0, 0, 2, 6);
        cyc(0, 0, 0, 2, 6);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 2, 6);
        cyc(1, 1, 0, 2, 6);
        cyc(0, 0, 0, 1, 7);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 7);
        cyc(0, 0, 0, 1, 3);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 15, 15);
        lo = 2; hi = 6;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                lo = $urandom_range(0, 15);
                hi = $urandom_range(0, 15);
                cyc(1, $urandom_range(0, 1), $urandom_range(0, 1), lo, hi);
            end else begin
                cyc(0, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                    $urandom_range(0, 15), $urandom_range(0, 15));
            end
        end
        @(negedge clk);
        reset = 1'b0; push = 1'b0; pop = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_status_ctrl.md
Name: fifo_status_ctrl

Overview:
- Occupancy and status tracker for the FIFO. Consumes the qualified push (write side) and pop (read side) strobes, and maintains the element count.
- Drives fifo_empty / fifo_full back into the read and write pointer logic.
- Provides almost-empty / almost-full flow-control flags with programmable thresholds.
- Provides sticky overflow / underflow error flags and a coarse state machine for the surrounding controller.

Parameters:
MEM_SIZE, 8, number of FIFO entries
PTR, 3, pointer width; count width is PTR+1 (covers 0..MEM_SIZE)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset, sampled on rising edge of clk
push  input  1  qualified write strobe (one entry written this cycle)
pop  input  1  qualified read strobe (one entry read this cycle)
umbral_bajo  input  PTR+1  almost-empty threshold, sampled only in INIT
umbral_alto  input  PTR+1  almost-full threshold, sampled only in INIT
fifo_count  output  PTR+1  current occupancy 0..MEM_SIZE
fifo_empty  output  1  fifo_count == 0
fifo_full  output  1  fifo_count == MEM_SIZE
almost_empty  output  1  fifo_count <= latched umbral_bajo
almost_full  output  1  fifo_count >= latched umbral_alto
error_overflow  output  1  sticky; push without pop while full
error_underflow  output  1  sticky; pop without push while empty
state  output  3  encoded FSM state

Behaviour:
Reset:
- reset=1 at a rising edge forces the following, regardless of push/pop that cycle:
  - fifo_count=0, state=INIT
  - both errors=0
  - latched thresholds=0
- Resulting flags: fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=1 (0>=0).
- Reset mid-operation discards all occupancy.

Flag timing:
- All flags are pure decodes of the registered count, thresholds and error bits. There is no combinational path from push/pop to any output.
- Flags change in the same cycle as fifo_count, one clock after the strobe edge.

Count update (any state except ERROR):
- push & !pop: +1
- pop & !push: -1
- push & pop: unchanged. This holds even when empty (read/write pass-through) or full.
- Neither: unchanged.
- Illegal cases:
  - push & !pop while count==MEM_SIZE: count holds, error_overflow<=1, state<=ERROR.
  - pop & !push while count==0: count holds, error_underflow<=1, state<=ERROR.
- No wrap-around of the count is ever allowed.

FSM states (encoding in package):
- INIT:
  - Lasts exactly one cycle after reset deasserts.
  - Latches umbral_bajo/umbral_alto into internal registers.
  - Processes push/pop normally.
  - Next state from the updated count: 0 -> IDLE, MEM_SIZE -> FULL, else ACTIVE. An illegal pop goes to ERROR.
- IDLE:
  - Count==0.
  - Legal push -> ACTIVE (or FULL if MEM_SIZE==1).
  - Illegal pop -> ERROR.
- ACTIVE:
  - 0 < count < MEM_SIZE.
  - Go to IDLE or FULL when the updated count reaches 0 or MEM_SIZE.
- FULL:
  - Count==MEM_SIZE.
  - Pop alone -> ACTIVE.
  - Push alone -> ERROR.
- ERROR:
  - Absorbing until reset.
  - Push/pop ignored; count, flags and thresholds frozen.
  - Both error bits are sticky; if they occur across states, both can be 1.
- Unused encodings recover to INIT on the next clock.

Thresholds:
- Changes to umbral_* outside INIT have no effect.
- umbral_alto > MEM_SIZE means almost_full is never set below full; no error is raised.

Decomposition:
- Shared package fifo_pkg holds:
  - state encodings INIT=0, IDLE=1, ACTIVE=2, FULL=3, ERROR=4
  - the count-width expression PTR+1
  - MEM_SIZE/PTR defaults, shared with the read/write logic
- No sub-module. Counter, FSM and flag decode stay in one file.

Test Plan:
- Reset, then reset=0 with umbral_bajo=2 and umbral_alto=6:
  - Cycle 1 is INIT, cycle 2 is IDLE.
  - fifo_empty=1, almost_empty=1, almost_full=0, count=0.
- 8 consecutive pushes from empty:
  - Count steps 1..8.
  - almost_empty drops when count=3; almost_full rises at count=6.
  - fifo_full=1 and state=FULL at count=8.
- At count=8, push+pop together:
  - Count stays 8, no error.
  - Then push alone: error_overflow=1, state=ERROR, count frozen at 8.
  - Further pops leave count at 8.
- From empty, push+pop together:
  - Count stays 0, fifo_empty stays 1, no underflow.
  - Then pop alone: error_underflow=1, state=ERROR.
- Fill to count=5, then assert reset for one cycle while push=1:
  - Count=0, errors=0, state=INIT.
  - New thresholds 1/7 presented during INIT are the ones used afterwards.
- Change umbral_alto to 3 while ACTIVE at count=4: almost_full stays 0.
